// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-length high windows separated
// by guaranteed low gaps, queuing events that arrive while a window or gap is active.
module pulse_stretcher #(
  parameter int ON_CYCLES  = 300000,
  parameter int OFF_CYCLES = 300000,
  parameter int CNT_W      = 22,
  parameter int PEND_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] counter;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      counter  <= '0;
      out      <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            state   <= S_ON;
            counter <= '0;
            out     <= 1'b1;
            busy    <= 1'b1;
          end
        end

        S_ON: begin
          if (trigger) begin
            if (pending == PEND_MAX) overflow <= 1'b1;
            else                     pending  <= pending + PEND_W'(1);
          end
          if (counter == ON_LAST) begin
            state   <= S_OFF;
            counter <= '0;
            out     <= 1'b0;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        S_OFF: begin
          if (counter == OFF_LAST) begin
            // A trigger in the final gap cycle either cancels the dequeue or is
            // consumed directly, so it never reaches the saturation check here.
            if (pending != '0) begin
              state   <= S_ON;
              counter <= '0;
              out     <= 1'b1;
              if (!trigger) pending <= pending - PEND_W'(1);
            end else if (trigger) begin
              state   <= S_ON;
              counter <= '0;
              out     <= 1'b1;
            end else begin
              state   <= S_IDLE;
              counter <= '0;
              busy    <= 1'b0;
            end
          end else begin
            counter <= counter + CNT_W'(1);
            if (trigger) begin
              if (pending == PEND_MAX) overflow <= 1'b1;
              else                     pending  <= pending + PEND_W'(1);
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          counter <= '0;
          out     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with ON=4, OFF=3, PEND_W=2; expected
// per-cycle waveforms are hand-written windows counted from reset release.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger;
  logic       out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [63:0] trigM, rstM, outM, busyM, ovfM;
  int          pendE [64];

  localparam int NCYC = 42;

  pulse_stretcher #(
    .ON_CYCLES (4),
    .OFF_CYCLES(3),
    .CNT_W     (22),
    .PEND_W    (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trigger (trigger),
    .out     (out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] span(int a, int b);
    logic [63:0] m;
    m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic compareBit(string tag, logic obs, logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic setPend(int a, int b, int v);
    for (int i = a; i <= b; i++) pendE[i] = v;
  endtask

  task automatic clearExp();
    trigM = '0;
    rstM  = '0;
    outM  = '0;
    busyM = '0;
    ovfM  = '0;
    for (int i = 0; i < 64; i++) pendE[i] = 0;
  endtask

  task automatic checkOutput(string scen, int c);
    compareBit($sformatf("%s out c%0d", scen, c), out, outM[c]);
    compareBit($sformatf("%s busy c%0d", scen, c), busy, busyM[c]);
    compareBit($sformatf("%s overflow c%0d", scen, c), overflow, ovfM[c]);
    compared++;
    assert (pending === 2'(pendE[c])) else begin
      mismatched++;
      $error("[TB] FAIL %s pending c%0d: observed %0d expected %0d", scen, c, pending, pendE[c]);
    end
  endtask

  // Holds rst with trigger asserted for three edges, then releases into cycle 0.
  task automatic resetDut(string scen);
    rst     = 1'b1;
    trigger = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      compareBit($sformatf("%s rst%0d out", scen, i), out, 1'b0);
      compareBit($sformatf("%s rst%0d busy", scen, i), busy, 1'b0);
      compareBit($sformatf("%s rst%0d overflow", scen, i), overflow, 1'b0);
      compareBit($sformatf("%s rst%0d pending0", scen, i), pending == 2'd0, 1'b1);
    end
    rst     = 1'b0;
    trigger = 1'b0;
    cyc     = 0;
  endtask

  task automatic applyStimulus(string scen);
    resetDut(scen);
    for (int c = 0; c < NCYC; c++) begin
      checkOutput(scen, c);
      trigger = trigM[c];
      rst     = rstM[c];
      step();
    end
    trigger = 1'b0;
    rst     = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    trigger = 1'b0;

    // Reset only: nothing happens with trigger idle after release.
    clearExp();
    applyStimulus("reset");

    // Single event.
    clearExp();
    trigM[10] = 1'b1;
    outM  = span(11, 14);
    busyM = span(11, 17);
    applyStimulus("single");

    // Queued events replayed in order.
    clearExp();
    trigM[10] = 1'b1; trigM[12] = 1'b1; trigM[16] = 1'b1;
    outM  = span(11, 14) | span(18, 21) | span(25, 28);
    busyM = span(11, 31);
    setPend(13, 16, 1);
    setPend(17, 17, 2);
    setPend(18, 24, 1);
    applyStimulus("queued");

    // Saturation and sticky overflow.
    clearExp();
    trigM[10] = 1'b1; trigM[12] = 1'b1; trigM[13] = 1'b1;
    trigM[14] = 1'b1; trigM[15] = 1'b1;
    outM  = span(11, 14) | span(18, 21) | span(25, 28) | span(32, 35);
    busyM = span(11, 38);
    ovfM  = span(16, NCYC - 1);
    setPend(13, 13, 1);
    setPend(14, 14, 2);
    setPend(15, 17, 3);
    setPend(18, 24, 2);
    setPend(25, 31, 1);
    applyStimulus("saturate");

    // Trigger in the final gap cycle with nothing queued.
    clearExp();
    trigM[10] = 1'b1; trigM[17] = 1'b1;
    outM  = span(11, 14) | span(18, 21);
    busyM = span(11, 24);
    applyStimulus("backtoback");

    // Reset mid-window discards the queue.
    clearExp();
    trigM[10] = 1'b1; trigM[12] = 1'b1;
    rstM[13]  = 1'b1;
    outM  = span(11, 13);
    busyM = span(11, 13);
    setPend(13, 13, 1);
    applyStimulus("abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
